// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver that shows a captured 32-bit word in hex.
// Every digit slot ends with one dark cycle so that the digit enables never overlap.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PCResult,
  input  logic [31:0] WriteData,
  input  logic        Capture,
  input  logic        Freeze,
  input  logic        Sel,
  output logic [6:0]  out7,
  output logic [7:0]  en_out
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(REFRESH_DIV - 1);

  logic [31:0]   shadow_pc;
  logic [31:0]   shadow_wd;
  logic [PW-1:0] prescaler;
  logic [2:0]    digit;

  logic [31:0] word;
  logic [3:0]  nibble;
  logic [2:0]  msnz;
  logic        lz_blank;
  logic        tc;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    word   = Sel ? shadow_wd : shadow_pc;
    nibble = word[{digit, 2'b00} +: 4];
    tc     = (prescaler == TC);
  end

  // Index of the most significant nonzero nibble; 0 for a zero word so digit 0 stays lit.
  always_comb begin
    msnz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (word[4*i +: 4] != 4'h0) msnz = 3'(i);
    end
    lz_blank = BLANK_LZ && (digit > msnz);
  end

  // Freeze outranks Capture; the scan itself runs independently of both.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow_pc <= 32'h0;
      shadow_wd <= 32'h0;
      prescaler <= '0;
      digit     <= 3'd0;
      out7      <= 7'h7F;
      en_out    <= 8'hFF;
    end else begin
      if (Capture && !Freeze) begin
        shadow_pc <= PCResult;
        shadow_wd <= WriteData;
      end
      if (tc) begin
        prescaler <= '0;
        digit     <= digit + 3'd1;
        out7      <= 7'h7F;
        en_out    <= 8'hFF;
      end else begin
        prescaler <= prescaler + PW'(1);
        en_out    <= ~(8'b1 << digit);
        out7      <= lz_blank ? 7'h7F : seg(nibble);
      end
    end
  end

endmodule
